// File: rtl/ttl_decrement_stage_if.sv
// ttl_decrement_stage_if: AXI4-Stream bundle (tdata/tstrb/tuser/tvalid/tlast/tready) with master/slave views
interface ttl_decrement_stage_if #(
  parameter int DATA_WIDTH = 256,
  parameter int USER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;
  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/ttl_decrement_stage.sv
// ttl_decrement_stage: IPv4 TTL decrement with incremental checksum update, TTL-expired redirect to paired CPU port.
// Define MAC_REWRITE_EN to also overwrite the source MAC of forwarded frames with the egress port's MAC.
module ttl_decrement_stage #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESET,
  ttl_decrement_stage_if.slave          s_axis,
  ttl_decrement_stage_if.master         m_axis,
  input  logic                          cnt_clear,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mac0_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mac0_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mac1_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mac1_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mac2_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mac2_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mac3_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mac3_high,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ttl_dec_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ttl_expired_count
);
  localparam logic [0:0] HDR = 1'b0;
  localparam logic [0:0] PAY = 1'b1;
  logic [0:0]                        state;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    nxt_data, skid_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  skid_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   nxt_user, skid_user;
  logic                              skid_last, skid_valid;
  logic                              accept, eligible, dec, expired, mac_hit;
  logic [7:0]                        src, dst, ttl;
  logic [15:0]                       csum, new_csum;
  logic [16:0]                       sum;
  logic [47:0]                       new_mac;
  logic                              unused_mac;
  assign s_axis.tready = !skid_valid && !AXI_RESET;
  assign accept   = s_axis.tvalid && s_axis.tready;
  assign src      = s_axis.tuser[SRC_PORT_POS +: 8];
  assign dst      = s_axis.tuser[DST_PORT_POS +: 8];
  assign ttl      = s_axis.tdata[79:72];
  assign csum     = s_axis.tdata[63:48];
  assign eligible = state == HDR && s_axis.tdata[159:144] == 16'h0800 && |(src & 8'h55);
  assign dec      = eligible && ttl >= 8'd2;
  assign expired  = eligible && ttl < 8'd2;
  // RFC 1624: adding ~0x0100 in one's complement removes one from the TTL/protocol word
  assign sum      = {1'b0, ~csum} + 17'h0FEFF;
  assign new_csum = ~(sum[15:0] + {15'b0, sum[16]});
`ifdef MAC_REWRITE_EN
  assign mac_hit    = |(dst & 8'h55);
  assign new_mac    = dst[0] ? {mac0_high[15:0], mac0_low} :
                      dst[2] ? {mac1_high[15:0], mac1_low} :
                      dst[4] ? {mac2_high[15:0], mac2_low} : {mac3_high[15:0], mac3_low};
  assign unused_mac = ^{mac0_high[C_S_AXI_DATA_WIDTH-1:16], mac1_high[C_S_AXI_DATA_WIDTH-1:16],
                        mac2_high[C_S_AXI_DATA_WIDTH-1:16], mac3_high[C_S_AXI_DATA_WIDTH-1:16]};
`else
  assign mac_hit    = 1'b0;
  assign new_mac    = '0;
  assign unused_mac = ^{mac0_low, mac0_high, mac1_low, mac1_high, mac2_low, mac2_high, mac3_low, mac3_high};
`endif
  always_comb begin
    nxt_data = s_axis.tdata;
    nxt_user = s_axis.tuser;
    if (dec) begin
      nxt_data[79:72] = ttl - 8'd1;
      nxt_data[63:48] = new_csum;
      if (mac_hit) nxt_data[207:160] = new_mac;
    end
    if (expired) nxt_user[DST_PORT_POS +: 8] = src << 1;
  end
  // Output register backed by a one-entry skid so tready can be registered without losing throughput
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state             <= HDR;
      skid_valid        <= 1'b0;
      skid_data         <= '0;
      skid_strb         <= '0;
      skid_user         <= '0;
      skid_last         <= 1'b0;
      m_axis.tvalid     <= 1'b0;
      m_axis.tdata      <= '0;
      m_axis.tstrb      <= '0;
      m_axis.tuser      <= '0;
      m_axis.tlast      <= 1'b0;
      ttl_dec_count     <= '0;
      ttl_expired_count <= '0;
    end else begin
      if (accept) state <= s_axis.tlast ? HDR : PAY;
      if (!m_axis.tvalid || m_axis.tready) begin
        m_axis.tvalid <= skid_valid || accept;
        skid_valid    <= 1'b0;
        if (skid_valid) begin
          m_axis.tdata <= skid_data;
          m_axis.tstrb <= skid_strb;
          m_axis.tuser <= skid_user;
          m_axis.tlast <= skid_last;
        end else if (accept) begin
          m_axis.tdata <= nxt_data;
          m_axis.tstrb <= s_axis.tstrb;
          m_axis.tuser <= nxt_user;
          m_axis.tlast <= s_axis.tlast;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= nxt_data;
        skid_strb  <= s_axis.tstrb;
        skid_user  <= nxt_user;
        skid_last  <= s_axis.tlast;
      end
      ttl_dec_count     <= cnt_clear ? '0 : ttl_dec_count + C_S_AXI_DATA_WIDTH'(accept && dec);
      ttl_expired_count <= cnt_clear ? '0 : ttl_expired_count + C_S_AXI_DATA_WIDTH'(accept && expired);
    end
  end
endmodule
